// File: rtl/ds1307_pkg.sv
// Shared constants, register indices, FSM states and BCD helper for the DS1307 target.
package ds1307_pkg;

  localparam logic [6:0] DS1307_ADDR = 7'h68;
  localparam int         CH_BIT      = 7;

  typedef enum logic [5:0] {
    REG_SEC   = 6'h00,
    REG_MIN   = 6'h01,
    REG_HOUR  = 6'h02,
    REG_DAY   = 6'h03,
    REG_DATE  = 6'h04,
    REG_MONTH = 6'h05,
    REG_YEAR  = 6'h06,
    REG_CTRL  = 6'h07,
    RAM_BASE  = 6'h08
  } reg_idx_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } state_e;

  // Modulo-60 BCD increment; returns {carry, tens[2:0], units[3:0]}.
  // A nibble that is already out of BCD range restarts at zero without carrying.
  function automatic logic [7:0] bcd_inc60(input logic [6:0] v);
    logic [3:0] lo;
    logic [2:0] hi;
    logic       c_lo;
    logic       c_hi;
    lo   = v[3:0];
    hi   = v[6:4];
    c_lo = 1'b0;
    c_hi = 1'b0;
    if (lo == 4'd9) begin
      lo   = 4'd0;
      c_lo = 1'b1;
    end else if (lo > 4'd9) begin
      lo = 4'd0;
    end else begin
      lo = lo + 4'd1;
    end
    if (c_lo) begin
      if (hi == 3'd5) begin
        hi   = 3'd0;
        c_hi = 1'b1;
      end else if (hi > 3'd5) begin
        hi = 3'd0;
      end else begin
        hi = hi + 3'd1;
      end
    end
    return {c_hi, hi, lo};
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises raw SCL/SDA pins and derives SCL edges plus START/STOP conditions.
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic scl_m, scl_s, scl_h;
  logic sda_m, sda_s, sda_h;

  // Reset to the idle-bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {scl_m, scl_s, scl_h} <= 3'b111;
      {sda_m, sda_s, sda_h} <= 3'b111;
    end else begin
      {scl_m, scl_s, scl_h} <= {scl_i, scl_m, scl_s};
      {sda_m, sda_s, sda_h} <= {sda_i, sda_m, sda_s};
    end
  end

  assign sda       = sda_s;
  assign scl_rise  = scl_s & ~scl_h;
  assign scl_fall  = ~scl_s & scl_h;
  assign start_det = scl_s & scl_h & sda_h & ~sda_s;
  assign stop_det  = scl_s & scl_h & ~sda_h & sda_s;

endmodule

// File: rtl/ds1307_i2c_target.sv
// DS1307-compatible I2C responder: 64-byte register map, pointer/burst access,
// and seconds/minutes advanced by an external 1 Hz tick.
module ds1307_i2c_target
  import ds1307_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = DS1307_ADDR,
  parameter int         HOLD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic       sec_tick,
  output logic       wr_stb,
  output logic [5:0] wr_addr,
  output logic [7:0] wr_dat,
  output logic       busy
);

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES);

  logic       sda, scl_rise, scl_fall, start_det, stop_det;
  state_e     state, state_nxt;
  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic       rw;
  logic [5:0] ptr, ptr_inc;
  logic [7:0] hold_cnt;
  logic       oe_target;
  logic [7:0] map [64];
  logic [7:0] byte_in, sec_inc, min_inc;
  logic       last_bit, map_we, tick_run;

  i2c_line_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign byte_in  = {shift[6:0], sda};
  assign last_bit = scl_rise & (bit_cnt == 3'd7);
  assign ptr_inc  = ptr + 6'd1;
  assign map_we   = last_bit & (state == ST_WR_DATA);
  assign tick_run = sec_tick & ~map[REG_SEC][CH_BIT];
  assign sec_inc  = bcd_inc60(map[REG_SEC][6:0]);
  assign min_inc  = bcd_inc60(map[REG_MIN][6:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stop_det) begin
      state_nxt = ST_IDLE;
    end else if (start_det) begin
      state_nxt = ST_ADDR;
    end else if (scl_rise) begin
      case (state)
        ST_ADDR:     if (last_bit) state_nxt = (byte_in[7:1] == SLAVE_ADDR) ? ST_ADDR_ACK : ST_WAIT_STOP;
        ST_ADDR_ACK: state_nxt = rw ? ST_RD_DATA : ST_PTR;
        ST_PTR,
        ST_WR_DATA:  if (last_bit) state_nxt = ST_WR_ACK;
        ST_WR_ACK:   state_nxt = ST_WR_DATA;
        ST_RD_DATA:  if (last_bit) state_nxt = ST_RD_ACK;
        ST_RD_ACK:   state_nxt = sda ? ST_WAIT_STOP : ST_RD_DATA;
        default:     state_nxt = state;
      endcase
    end
  end

  always_comb begin
    case (state)
      ST_ADDR_ACK, ST_WR_ACK: oe_target = 1'b1;
      ST_RD_DATA:             oe_target = ~shift[7];
      default:                oe_target = 1'b0;
    endcase
  end

  // SDA only moves once the hold window after an SCL fall has elapsed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      sda_oe   <= 1'b0;
    end else if (start_det || stop_det) begin
      hold_cnt <= '0;
      sda_oe   <= 1'b0;
    end else if (scl_fall) begin
      hold_cnt <= HOLD_INIT;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - 8'd1;
      if (hold_cnt == 8'd1) sda_oe <= oe_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift   <= '0;
      bit_cnt <= '0;
      rw      <= 1'b0;
      ptr     <= '0;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_dat  <= '0;
    end else begin
      wr_stb <= 1'b0;
      if (start_det) begin
        bit_cnt <= '0;
      end else if (stop_det) begin
        bit_cnt <= '0;
        busy    <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          ST_ADDR: begin
            shift   <= byte_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) begin
              rw   <= byte_in[0];
              busy <= (byte_in[7:1] == SLAVE_ADDR);
            end
          end
          ST_ADDR_ACK: if (rw) shift <= map[ptr];
          ST_PTR: begin
            shift   <= byte_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) ptr <= byte_in[5:0];
          end
          ST_WR_DATA: begin
            shift   <= byte_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) begin
              wr_stb  <= 1'b1;
              wr_addr <= ptr;
              wr_dat  <= byte_in;
              ptr     <= ptr_inc;
            end
          end
          ST_RD_DATA: begin
            shift   <= {shift[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end
          ST_RD_ACK: begin
            ptr <= ptr_inc;
            if (!sda) shift <= map[ptr_inc];
            else      busy  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // The I2C write is assigned last so it overrides a same-cycle tick update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) map[i] <= '0;
    end else begin
      if (tick_run) begin
        map[REG_SEC] <= {map[REG_SEC][7], sec_inc[6:0]};
        if (sec_inc[7]) map[REG_MIN] <= {map[REG_MIN][7], min_inc[6:0]};
      end
      if (map_we) map[ptr] <= byte_in;
    end
  end

endmodule

// File: tb/tb_ds1307_i2c_target.sv
// Directed bench for ds1307_i2c_target: bit-banged I2C master, wired-AND SDA, write log.
module tb_ds1307_i2c_target;

  localparam int Q = 16;

  typedef struct {
    logic [7:0] ptr_byte;
    logic [7:0] data;
    logic [5:0] exp_addr;
    logic [7:0] exp_rd;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sec_tick = 1'b0;
  logic       sda_line;
  logic       sda_oe, wr_stb, busy;
  logic [5:0] wr_addr;
  logic [7:0] wr_dat;

  int         checks = 0;
  int         failures = 0;
  int         oe_cnt = 0;
  logic [5:0] log_addr[$];
  logic [7:0] log_dat[$];
  logic [7:0] rd_buf[8];
  logic [7:0] wr_buf[4];

  assign sda_line = sda_m & ~sda_oe;

  ds1307_i2c_target dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_i    (scl_m),
    .sda_i    (sda_line),
    .sda_oe   (sda_oe),
    .sec_tick (sec_tick),
    .wr_stb   (wr_stb),
    .wr_addr  (wr_addr),
    .wr_dat   (wr_dat),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb) begin
      log_addr.push_back(wr_addr);
      log_dat.push_back(wr_dat);
    end
    if (sda_oe) oe_cnt++;
  end

  task automatic waitClks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic i2cStart();
    sda_m = 1'b1; waitClks(Q);
    scl_m = 1'b1; waitClks(Q);
    sda_m = 1'b0; waitClks(Q);
    scl_m = 1'b0; waitClks(Q);
  endtask

  task automatic i2cStop();
    sda_m = 1'b0; waitClks(Q);
    scl_m = 1'b1; waitClks(Q);
    sda_m = 1'b1; waitClks(Q);
  endtask

  // One SCL period; s = SDA mid-high, e = sda_oe shortly after the fall.
  task automatic i2cBit(input logic b, output logic s, output logic e);
    sda_m = b;    waitClks(Q);
    scl_m = 1'b1; waitClks(Q / 2);
    s = sda_line; waitClks(Q / 2);
    scl_m = 1'b0; waitClks(5);
    e = sda_oe;   waitClks(Q - 5);
  endtask

  task automatic writeByte(input logic [7:0] b, output logic ack, output logic early);
    logic s, e;
    for (int i = 7; i >= 0; i--) i2cBit(b[i], s, e);
    early = e;
    i2cBit(1'b1, s, e);
    ack = ~s;
  endtask

  task automatic readByte(input logic nack, output logic [7:0] d);
    logic s, e;
    for (int i = 7; i >= 0; i--) begin
      i2cBit(1'b1, s, e);
      d[i] = s;
    end
    i2cBit(nack, s, e);
  endtask

  task automatic writeRegs(input logic [7:0] ptr_byte, input int n);
    logic ack, early;
    i2cStart();
    writeByte(8'hD0, ack, early);    checkOutput("wr_sla_ack", ack, 1);
    writeByte(ptr_byte, ack, early); checkOutput("wr_ptr_ack", ack, 1);
    for (int k = 0; k < n; k++) begin
      writeByte(wr_buf[k], ack, early);
      checkOutput($sformatf("wr_data%0d_ack", k), ack, 1);
    end
    i2cStop();
  endtask

  task automatic readRegs(input logic [7:0] ptr_byte, input int n);
    logic ack, early;
    logic [7:0] d;
    i2cStart();
    writeByte(8'hD0, ack, early);    checkOutput("rd_sla_w_ack", ack, 1);
    writeByte(ptr_byte, ack, early); checkOutput("rd_ptr_ack", ack, 1);
    i2cStart();
    writeByte(8'hD1, ack, early);    checkOutput("rd_sla_r_ack", ack, 1);
    for (int k = 0; k < n; k++) begin
      readByte(k == n - 1, d);
      rd_buf[k] = d;
    end
    i2cStop();
  endtask

  task automatic pulseTick();
    sec_tick = 1'b1; waitClks(1);
    sec_tick = 1'b0; waitClks(4);
  endtask

  task automatic applyStimulus(input vec_t v);
    wr_buf[0] = v.data;
    writeRegs(v.ptr_byte, 1);
    readRegs(v.ptr_byte, 1);
  endtask

  initial begin
    vec_t       vecs[4];
    logic       ack, early, s, e;
    logic [7:0] d;
    int         n0, c0;

    vecs[0] = '{8'h08, 8'hA5, 6'h08, 8'hA5};
    vecs[1] = '{8'hC9, 8'h3C, 6'h09, 8'h3C};
    vecs[2] = '{8'h20, 8'hFF, 6'h20, 8'hFF};
    vecs[3] = '{8'h7E, 8'h01, 6'h3E, 8'h01};

    waitClks(5);
    checkOutput("rst_sda_oe", sda_oe, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_wr_stb", wr_stb, 0);
    checkOutput("rst_wr_addr", wr_addr, 0);
    checkOutput("rst_wr_dat", wr_dat, 0);
    rst_n = 1'b1;
    waitClks(5);

    // Pointer 0 then burst write, repeated START into a burst read from ptr 3.
    n0 = log_addr.size();
    wr_buf[0] = 8'h00; wr_buf[1] = 8'h30; wr_buf[2] = 8'h45; wr_buf[3] = 8'h12;
    i2cStart();
    writeByte(8'hD0, ack, early);
    checkOutput("sla_w_ack", ack, 1);
    checkOutput("ack_hold_early", early, 0);
    checkOutput("busy_after_ack", busy, 1);
    for (int k = 0; k < 4; k++) begin
      writeByte(wr_buf[k], ack, early);
      checkOutput($sformatf("burst_ack%0d", k), ack, 1);
    end
    checkOutput("burst_stb_count", log_addr.size() - n0, 3);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("burst_addr%0d", k), log_addr[n0 + k], k);
      checkOutput($sformatf("burst_dat%0d", k), log_dat[n0 + k], wr_buf[k + 1]);
    end
    i2cStart();
    writeByte(8'hD1, ack, early);
    checkOutput("sla_r_ack", ack, 1);
    for (int k = 0; k < 3; k++) begin
      readByte(k == 2, d);
      checkOutput($sformatf("rd_ptr3_byte%0d", k), d, 0);
    end
    checkOutput("busy_after_nack", busy, 0);
    i2cStop();

    wr_buf[0] = 8'h77;
    writeRegs(8'h03, 1);
    readRegs(8'h00, 3);
    checkOutput("rd0", rd_buf[0], 8'h30);
    checkOutput("rd1", rd_buf[1], 8'h45);
    checkOutput("rd2", rd_buf[2], 8'h12);
    i2cStart();
    writeByte(8'hD1, ack, early);
    readByte(1'b1, d);
    i2cStop();
    checkOutput("ptr_ends_3", d, 8'h77);

    for (int i = 0; i < 4; i++) begin
      n0 = log_addr.size();
      applyStimulus(vecs[i]);
      checkOutput($sformatf("tbl%0d_stb", i), log_addr.size() - n0, 1);
      checkOutput($sformatf("tbl%0d_wr_addr", i), log_addr[n0], vecs[i].exp_addr);
      checkOutput($sformatf("tbl%0d_wr_dat", i), log_dat[n0], vecs[i].data);
      checkOutput($sformatf("tbl%0d_rd", i), rd_buf[0], vecs[i].exp_rd);
    end

    // Foreign address must never see SDA pulled or a write strobe.
    n0 = log_addr.size();
    c0 = oe_cnt;
    i2cStart();
    writeByte(8'hA0, ack, early);
    checkOutput("foreign_sla_ack", ack, 0);
    writeByte(8'h55, ack, early);
    checkOutput("foreign_data_ack", ack, 0);
    checkOutput("foreign_busy", busy, 0);
    i2cStop();
    checkOutput("foreign_oe_cycles", oe_cnt - c0, 0);
    checkOutput("foreign_stb", log_addr.size() - n0, 0);

    n0 = log_addr.size();
    wr_buf[0] = 8'hAA; wr_buf[1] = 8'h55;
    writeRegs(8'h3F, 2);
    checkOutput("wrap_addr0", log_addr[n0], 6'h3F);
    checkOutput("wrap_addr1", log_addr[n0 + 1], 6'h00);
    readRegs(8'h3F, 2);
    checkOutput("wrap_rd0", rd_buf[0], 8'hAA);
    checkOutput("wrap_rd1", rd_buf[1], 8'h55);

    wr_buf[0] = 8'h59; wr_buf[1] = 8'h59;
    writeRegs(8'h00, 2);
    pulseTick();
    readRegs(8'h00, 2);
    checkOutput("tick_sec_wrap", rd_buf[0], 8'h00);
    checkOutput("tick_min_wrap", rd_buf[1], 8'h00);
    wr_buf[0] = 8'h80;
    writeRegs(8'h00, 1);
    pulseTick();
    readRegs(8'h00, 2);
    checkOutput("tick_halt_sec", rd_buf[0], 8'h80);
    checkOutput("tick_halt_min", rd_buf[1], 8'h00);
    wr_buf[0] = 8'h12;
    writeRegs(8'h00, 1);
    pulseTick();
    readRegs(8'h00, 1);
    checkOutput("tick_sec_inc", rd_buf[0], 8'h13);

    // STOP in the middle of a data byte.
    n0 = log_addr.size();
    i2cStart();
    writeByte(8'hD0, ack, early);
    writeByte(8'h10, ack, early);
    for (int k = 0; k < 4; k++) i2cBit(1'b1, s, e);
    i2cStop();
    checkOutput("abort_stb", log_addr.size() - n0, 0);
    checkOutput("abort_busy", busy, 0);
    readRegs(8'h10, 1);
    checkOutput("abort_map", rd_buf[0], 8'h00);

    // Reset while the target drives a 0 data bit.
    i2cStart();
    writeByte(8'hD0, ack, early);
    writeByte(8'h11, ack, early);
    i2cStart();
    writeByte(8'hD1, ack, early);
    checkOutput("rd_drive_zero", sda_oe, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_oe", sda_oe, 0);
    checkOutput("rst_async_busy", busy, 0);
    waitClks(3);
    checkOutput("rst_wr_dat_clr", wr_dat, 0);
    sda_m = 1'b1;
    rst_n = 1'b1;
    waitClks(Q);
    scl_m = 1'b1;
    waitClks(Q);
    readRegs(8'h08, 1);
    checkOutput("rst_map_clear", rd_buf[0], 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
